mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits directly downstream of the coherence controller, between the bus side and the single-port RAM.
- Merges three requesters onto the one RAM port:
  - the coherence controller's data-side RAM port (word reads and writes);
  - instruction fetches from the two icaches.
- Returns RAM status and data to whichever requester holds the grant.
- Grant priority: data first, with a bounded-starvation guarantee for instruction fetch; round-robin between the two icaches.

Parameters:
- DATA_BURST_MAX, 4: maximum consecutive data grants while any instruction request is pending. The next grant then goes to instruction. Legal range 1..15.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- cc_ramREN  in  1  data-side read request from coherence controller
- cc_ramWEN  in  1  data-side write request from coherence controller
- cc_ramaddr  in  32  data-side word address
- cc_ramstore  in  32  data-side write data
- cc_ramstate  out  2  RAM state returned to coherence controller
- cc_ramload  out  32  read data returned to coherence controller
- iREN  in  2  instruction read request, one bit per core
- iaddr  in  2x32  instruction address, one word per core
- iwait  out  2  per-core instruction wait; 0 means iload is valid this cycle
- iload  out  2x32  per-core instruction data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramstate  in  2  RAM state: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- ramload  in  32  RAM read data

Behaviour:
- Registered state:
  - FSM state: IDLE, DGRANT, IGRANT.
  - igid (1 bit): granted core.
  - rr (1 bit): round-robin pointer.
  - dcount (4 bits): consecutive data-grant counter.
- Reset: state=IDLE, igid=0, rr=0, dcount=0.
- Default outputs (reset and IDLE):
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0
  - cc_ramstate=BUSY, cc_ramload=0
  - iwait=2'b11, iload=0
- Data request definition: dreq = cc_ramREN | cc_ramWEN. If both are asserted, the write wins: ramWEN=1, ramREN=0.
- IDLE, evaluated in priority order:
  1. If iREN!=0 and (dcount==DATA_BURST_MAX or !dreq): go to IGRANT. igid=rr if both iREN bits are set, otherwise the asserted core.
  2. Else if dreq: go to DGRANT.
  3. Else stay in IDLE.
  - Nothing reaches the RAM in the decision cycle. Minimum latency: request in cycle 0, RAM driven from cycle 1.
- DGRANT:
  - RAM port is driven combinationally from cc_ram* inputs.
  - cc_ramstate = ramstate; cc_ramload = ramload.
  - On ramstate==ACCESS: go to IDLE. If iREN!=0 at that cycle, dcount = min(dcount+1, DATA_BURST_MAX); otherwise dcount=0.
  - If dreq drops before ACCESS (abort): go to IDLE, dcount unchanged, nothing delivered.
  - ERROR is passed through; the grant is held.
- IGRANT:
  - ramREN=1, ramaddr=iaddr[igid].
  - cc_ramstate=BUSY.
  - On ramstate==ACCESS: iwait[igid]=0, iload[igid]=ramload, rr=~igid, dcount=0, go to IDLE.
  - If iREN[igid] drops before ACCESS: abort to IDLE, rr unchanged.
  - The non-granted core always sees iwait=1, iload=0.
- Completion pulses are one cycle wide. A requester that holds its request after completion is re-arbitrated from IDLE.
- Inter-word gaps: the coherence controller drops its request between the two words of a block. An instruction fetch may legally be granted in that gap; the controller waits because it sees BUSY.
- Reset asserted mid-grant: state returns to IDLE immediately and all outputs take their reset values in the same cycle. No RAM enable stays asserted.
- An ACCESS seen in IDLE is ignored.

Test Plan:
- Single instruction fetch: iREN=2'b01, iaddr[0]=0x0000_0040, RAM returns ACCESS after 2 BUSY cycles with ramload=0x2402_0001 -> ramREN=1 from cycle 1; iwait[0]=0 for exactly one cycle with iload[0]=0x2402_0001; iwait[1]=1 throughout.
- Data write: cc_ramWEN=1, cc_ramaddr=0x0000_0100, cc_ramstore=0xDEAD_BEEF -> ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF; cc_ramstate mirrors ramstate and equals ACCESS in the completion cycle; iwait stays 2'b11.
- Contention with DATA_BURST_MAX=4: dreq and iREN=2'b10 held continuously -> grant sequence is 4 data, 1 instruction (core 1), 4 data, and so on.
- Round-robin: iREN=2'b11 held continuously, no data requests -> grants alternate core 0, 1, 0, 1 starting from core 0 after reset.
- Abort and reset: cc_ramREN dropped in DGRANT before ACCESS -> IDLE next cycle with dcount unchanged. nRST pulsed low mid-IGRANT -> ramREN=0 and iwait=2'b11 in the same cycle; no completion pulse is delivered.
- Both enables set: cc_ramREN=1 and cc_ramWEN=1 -> ramWEN=1, ramREN=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Merges the coherence controller's data port and two icache fetch ports onto one RAM port.
// Latency: one arbitration cycle in IDLE, then the RAM is driven until ACCESS; completion pulses are one cycle.
// Backpressure: requesters hold their request; the losers see BUSY (data side) or iwait=1 (icache side).
//
// Ports:
//   CLK, nRST                  clock, asynchronous active-low reset
//   cc_ram{REN,WEN,addr,store} data-side request from the coherence controller
//   cc_ram{state,load}         RAM status/data returned to the coherence controller
//   iREN, iaddr                per-core instruction fetch request and word address
//   iwait, iload               per-core fetch wait (0 = iload valid) and fetch data
//   ram{REN,WEN,addr,store}    single RAM port request
//   ram{state,load}            RAM status (FREE/BUSY/ACCESS/ERROR) and read data
module mem_arbiter #(
    // Consecutive data grants allowed while an instruction fetch waits (1..15).
    parameter int unsigned DATA_BURST_MAX = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             cc_ramREN,
    input  logic             cc_ramWEN,
    input  logic [31:0]      cc_ramaddr,
    input  logic [31:0]      cc_ramstore,
    output logic [1:0]       cc_ramstate,
    output logic [31:0]      cc_ramload,
    input  logic [1:0]       iREN,
    input  logic [1:0][31:0] iaddr,
    output logic [1:0]       iwait,
    output logic [1:0][31:0] iload,
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore,
    input  logic [1:0]       ramstate,
    input  logic [31:0]      ramload
);

    localparam logic [1:0] RAM_BUSY   = 2'd1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [3:0] BURST_MAX  = 4'(DATA_BURST_MAX);

    typedef enum logic [1:0] {
        IDLE,
        DGRANT,
        IGRANT
    } state_t;

    state_t     state, state_n;
    logic       igid, igid_n;
    logic       rr, rr_n;
    logic [3:0] dcount, dcount_n;

    logic dreq;
    logic ireq;

    assign dreq = cc_ramREN | cc_ramWEN;
    assign ireq = |iREN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            igid   <= 1'b0;
            rr     <= 1'b0;
            dcount <= 4'd0;
        end else begin
            state  <= state_n;
            igid   <= igid_n;
            rr     <= rr_n;
            dcount <= dcount_n;
        end
    end

    always_comb begin
        state_n     = state;
        igid_n      = igid;
        rr_n        = rr;
        dcount_n    = dcount;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        cc_ramstate = RAM_BUSY;
        cc_ramload  = '0;
        iwait       = 2'b11;
        iload       = '0;

        case (state)
            IDLE: begin
                // Instruction wins when data is absent or has used up its burst allowance.
                if (ireq && (dcount == BURST_MAX || !dreq)) begin
                    state_n = IGRANT;
                    igid_n  = (iREN == 2'b11) ? rr : iREN[1];
                end else if (dreq) begin
                    state_n = DGRANT;
                end
            end

            DGRANT: begin
                // A combined read+write request is treated as a write.
                ramWEN      = cc_ramWEN;
                ramREN      = cc_ramREN & ~cc_ramWEN;
                ramaddr     = cc_ramaddr;
                ramstore    = cc_ramstore;
                cc_ramstate = ramstate;
                cc_ramload  = ramload;
                if (!dreq) begin
                    // Abort: the burst counter is left as it was.
                    state_n = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    state_n = IDLE;
                    if (!ireq) begin
                        dcount_n = 4'd0;
                    end else if (dcount >= BURST_MAX) begin
                        dcount_n = BURST_MAX;
                    end else begin
                        dcount_n = dcount + 4'd1;
                    end
                end
            end

            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[igid];
                if (!iREN[igid]) begin
                    state_n = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    iwait[igid] = 1'b0;
                    iload[igid] = ramload;
                    rr_n        = ~igid;
                    dcount_n    = 4'd0;
                    state_n     = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic against a RAM model,
// with a scoreboard that tracks expected data and the expected grant order.
module tb_mem_arbiter;

    localparam int         MAX    = 4;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             cc_ramREN, cc_ramWEN;
    logic [31:0]      cc_ramaddr, cc_ramstore;
    logic [1:0]       cc_ramstate;
    logic [31:0]      cc_ramload;
    logic [1:0]       iREN;
    logic [1:0][31:0] iaddr;
    logic [1:0]       iwait;
    logic [1:0][31:0] iload;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore;
    logic [1:0]       ramstate;
    logic [31:0]      ramload;

    mem_arbiter #(.DATA_BURST_MAX(MAX)) dut (
        .CLK(CLK), .nRST(nRST),
        .cc_ramREN(cc_ramREN), .cc_ramWEN(cc_ramWEN),
        .cc_ramaddr(cc_ramaddr), .cc_ramstore(cc_ramstore),
        .cc_ramstate(cc_ramstate), .cc_ramload(cc_ramload),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramstate(ramstate), .ramload(ramload)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_s(input string name, input string got, input string exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %s expected %s", name, got, exp);
        end
    endtask

    function automatic logic [31:0] hashw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- RAM model: BUSY for 'lat' cycles, then ACCESS ----------------
    logic [31:0] mem [256];
    logic [3:0]  ram_cnt = 4'd0;
    logic [3:0]  rlat = 4'd0;
    logic [3:0]  ram_lat;
    logic        lat_rand;
    logic        mem_init;
    logic        ram_en;
    logic [3:0]  cur_lat;

    assign ram_en  = ramREN | ramWEN;
    assign cur_lat = lat_rand ? rlat : ram_lat;
    assign ramload = mem[ramaddr[9:2]];

    always_comb begin
        ramstate = FREE;
        if (ram_en) ramstate = (ram_cnt >= cur_lat) ? ACCESS : BUSY;
    end

    always @(posedge CLK) begin
        if (ram_en && ramstate != ACCESS) begin
            ram_cnt <= ram_cnt + 4'd1;
        end else begin
            ram_cnt <= 4'd0;
            rlat    <= 4'($urandom_range(0, 3));
        end
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= hashw(32'(i) * 4);
            mem[16] <= 32'h2402_0001;
        end else if (ramWEN && ramstate == ACCESS) begin
            mem[ramaddr[9:2]] <= ramstore;
        end
    end

    // ---------------- Scoreboard ----------------
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } dexp_t;

    dexp_t       dq[$];
    logic [31:0] iq0[$];
    logic [31:0] iq1[$];
    logic [31:0] ref_mem [256];
    logic        mon_en = 1'b0;

    logic        p_en, p_dreq, m_rr, m_gcore, exp_i, got_i;
    logic [1:0]  p_iren;
    int          m_streak;
    dexp_t       de;

    task automatic icheck(input int c);
        logic [31:0] e;
        if ((c == 0 && iq0.size() == 0) || (c == 1 && iq1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL ifetch_unexpected: core %0d completed with iload %h, none expected", c, iload[c]);
        end else begin
            e = (c == 0) ? iq0.pop_front() : iq1.pop_front();
            chk($sformatf("ifetch_load_core%0d", c), iload[c], e);
            chk($sformatf("ifetch_granted_core%0d", c), 32'(c), 32'(m_gcore));
            chk($sformatf("ifetch_other_load_core%0d", c), iload[1-c], 32'h0);
        end
        m_rr     = ~c[0];
        m_streak = 0;
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (!mon_en) begin
                p_en = 1'b0; p_iren = 2'b00; p_dreq = 1'b0;
                m_streak = 0; m_rr = 1'b0; m_gcore = 1'b0;
            end else begin
                // A grant begins on the first enabled cycle after an idle one; the decision used last cycle's inputs.
                if (ram_en && !p_en) begin
                    exp_i = (p_iren != 2'b00) && (m_streak == MAX || !p_dreq);
                    got_i = ramREN && !ramWEN && (ramaddr < 32'h200);
                    chk("grant_kind_is_instr", 32'(got_i), 32'(exp_i));
                    if (exp_i) m_gcore = (p_iren == 2'b11) ? m_rr : p_iren[1];
                end
                if (iwait == 2'b00) chk("iwait_both_low", 32'(iwait), 32'h3);
                if (cc_ramstate == ACCESS) begin
                    if (dq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL data_unexpected: completion at addr %h, none expected", ramaddr);
                    end else begin
                        de = dq.pop_front();
                        chk("data_addr", ramaddr, de.addr);
                        if (de.wr) begin
                            chk("data_wen", 32'(ramWEN), 32'h1);
                            chk("data_ren", 32'(ramREN), 32'h0);
                            chk("data_store", ramstore, de.data);
                        end else begin
                            chk("data_load", cc_ramload, de.data);
                        end
                    end
                    if (iREN != 2'b00) m_streak = (m_streak + 1 > MAX) ? MAX : m_streak + 1;
                    else               m_streak = 0;
                end
                if (!iwait[0]) icheck(0);
                if (!iwait[1]) icheck(1);
                p_en   = ram_en;
                p_iren = iREN;
                p_dreq = cc_ramREN | cc_ramWEN;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- Stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic samp();
        @(negedge CLK);
    endtask

    string       got;
    int          n, pulses, first, bad, found;
    logic        pe;
    bit          d_act, issue;
    bit [1:0]    i_act;
    int          d_gap;
    int          i_gap [2];
    logic        d_done;
    logic [1:0]  i_done;
    logic [31:0] a, d;
    int          op;

    initial begin
        nRST = 1'b0; mem_init = 1'b1; lat_rand = 1'b0; ram_lat = 4'd0;
        cc_ramREN = 1'b0; cc_ramWEN = 1'b0; cc_ramaddr = '0; cc_ramstore = '0;
        iREN = 2'b00; iaddr = '0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1; mem_init = 1'b0;

        // Reset / idle outputs
        samp();
        chk("rst_ramREN", 32'(ramREN), 32'h0);
        chk("rst_ramWEN", 32'(ramWEN), 32'h0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        chk("rst_cc_ramstate", 32'(cc_ramstate), 32'(BUSY));
        chk("rst_cc_ramload", cc_ramload, 32'h0);
        chk("rst_iwait", 32'(iwait), 32'h3);
        chk("rst_iload", iload[0] | iload[1], 32'h0);

        // Single instruction fetch, two BUSY cycles
        ram_lat = 4'd2;
        tick();
        iREN = 2'b01; iaddr[0] = 32'h40;
        pulses = 0; first = -1; bad = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            samp();
            if (cyc == 0) chk("if_decision_ramREN", 32'(ramREN), 32'h0);
            if (cyc == 1) begin
                chk("if_ramREN", 32'(ramREN), 32'h1);
                chk("if_ramaddr", ramaddr, 32'h40);
            end
            if (iwait[1] !== 1'b1) bad++;
            if (!iwait[0]) begin
                pulses++;
                if (first < 0) first = cyc;
                chk("if_iload", iload[0], 32'h2402_0001);
            end
            tick();
            if (pulses > 0) iREN = 2'b00;
        end
        chk("if_pulse_count", 32'(pulses), 32'd1);
        chk("if_done_cycle", 32'(first), 32'd3);
        chk("if_iwait1_high", 32'(bad), 32'd0);

        // Data write
        ram_lat = 4'd1;
        tick();
        cc_ramWEN = 1'b1; cc_ramaddr = 32'h100; cc_ramstore = 32'hDEAD_BEEF;
        samp();
        chk("dw_decision_ramWEN", 32'(ramWEN), 32'h0);
        tick(); samp();
        chk("dw_ramWEN", 32'(ramWEN), 32'h1);
        chk("dw_ramREN", 32'(ramREN), 32'h0);
        chk("dw_ramaddr", ramaddr, 32'h100);
        chk("dw_ramstore", ramstore, 32'hDEAD_BEEF);
        chk("dw_state_busy", 32'(cc_ramstate), 32'(BUSY));
        chk("dw_iwait", 32'(iwait), 32'h3);
        tick(); samp();
        chk("dw_state_access", 32'(cc_ramstate), 32'(ACCESS));
        chk("dw_iwait_done", 32'(iwait), 32'h3);
        tick();
        cc_ramWEN = 1'b0;
        samp();
        chk("dw_idle_state", 32'(cc_ramstate), 32'(BUSY));

        // Both enables: write wins
        ram_lat = 4'd3;
        tick();
        cc_ramREN = 1'b1; cc_ramWEN = 1'b1; cc_ramaddr = 32'h208; cc_ramstore = 32'h1234_5678;
        tick(); samp();
        chk("both_ramWEN", 32'(ramWEN), 32'h1);
        chk("both_ramREN", 32'(ramREN), 32'h0);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            tick(); samp();
            if (cc_ramstate == ACCESS) found = 1;
        end
        chk("both_done", 32'(found), 32'h1);
        tick();
        cc_ramREN = 1'b0; cc_ramWEN = 1'b0;

        // Contention: data + core 1 held continuously
        ram_lat = 4'd0;
        tick();
        cc_ramREN = 1'b1; cc_ramaddr = 32'h200; iREN = 2'b10; iaddr[1] = 32'h80;
        got = ""; n = 0; pe = 1'b0; pulses = 0; bad = 0;
        for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
            samp();
            if (ram_en && !pe) begin
                got = {got, (ramaddr == 32'h80) ? "I" : "D"};
                n++;
            end
            pe = ram_en;
            if (!iwait[1]) pulses++;
            if (!iwait[0]) bad++;
            tick();
        end
        cc_ramREN = 1'b0; iREN = 2'b00;
        chk_s("contention_grant_seq", got, "DDDDIDDDDI");
        chk("contention_core1_done", 32'(pulses), 32'd2);
        chk("contention_core0_idle", 32'(bad), 32'd0);

        // Round-robin from reset
        tick(); nRST = 1'b0;
        tick(); nRST = 1'b1;
        ram_lat = 4'd1;
        tick();
        iREN = 2'b11; iaddr[0] = 32'h84; iaddr[1] = 32'h88;
        got = ""; n = 0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            samp();
            if (!iwait[0]) begin got = {got, "0"}; n++; end
            if (!iwait[1]) begin got = {got, "1"}; n++; end
            tick();
        end
        iREN = 2'b00;
        chk_s("rr_core_seq", got, "0101");

        // Data abort keeps the burst count: 2 data, abort, then expect D D I
        ram_lat = 4'd0;
        tick();
        cc_ramREN = 1'b1; cc_ramaddr = 32'h204; iREN = 2'b01; iaddr[0] = 32'h8C;
        n = 0; pe = 1'b0;
        for (int cyc = 0; cyc < 20 && n < 2; cyc++) begin
            samp();
            if (ram_en && !pe) n++;
            pe = ram_en;
            if (n < 2) tick();
        end
        chk("ab_setup_grants", 32'(n), 32'd2);
        tick();
        ram_lat = 4'd5;
        samp(); tick(); samp();
        chk("ab_grant_ramREN", 32'(ramREN), 32'h1);
        chk("ab_grant_busy", 32'(cc_ramstate), 32'(BUSY));
        tick();
        cc_ramREN = 1'b0; iREN = 2'b00;
        samp();
        chk("ab_drop_state_mirror", 32'(cc_ramstate), 32'(FREE));
        tick(); samp();
        chk("ab_idle_state", 32'(cc_ramstate), 32'(BUSY));
        chk("ab_idle_ramREN", 32'(ramREN), 32'h0);
        ram_lat = 4'd0;
        tick();
        cc_ramREN = 1'b1; iREN = 2'b01;
        got = ""; n = 0; pe = 1'b0;
        for (int cyc = 0; cyc < 30 && n < 3; cyc++) begin
            samp();
            if (ram_en && !pe) begin
                got = {got, (ramaddr == 32'h8C) ? "I" : "D"};
                n++;
            end
            pe = ram_en;
            tick();
        end
        cc_ramREN = 1'b0; iREN = 2'b00;
        chk_s("ab_resume_seq", got, "DDI");

        // Reset in the middle of an instruction grant
        ram_lat = 4'd5;
        tick();
        iREN = 2'b01; iaddr[0] = 32'h90;
        samp(); tick(); samp();
        chk("rstmid_pre_ramREN", 32'(ramREN), 32'h1);
        #2;
        nRST = 1'b0;
        #1;
        chk("rstmid_ramREN", 32'(ramREN), 32'h0);
        chk("rstmid_ramaddr", ramaddr, 32'h0);
        chk("rstmid_iwait", 32'(iwait), 32'h3);
        bad = 0;
        repeat (3) begin
            samp();
            if (iwait != 2'b11 || ramREN) bad++;
        end
        tick();
        iREN = 2'b00; nRST = 1'b1;
        repeat (4) begin
            samp();
            if (iwait != 2'b11 || ramREN) bad++;
        end
        chk("rstmid_no_completion", 32'(bad), 32'd0);

        // Randomized traffic
        tick();
        nRST = 1'b0; mem_init = 1'b1;
        tick();
        nRST = 1'b1; mem_init = 1'b0; lat_rand = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = hashw(32'(i) * 4);
        mon_en = 1'b1;
        d_act = 1'b0; d_gap = 0; i_act = 2'b00; i_gap[0] = 0; i_gap[1] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            issue = (cyc < 3000);
            if (!issue && !d_act && i_act == 2'b00) break;
            samp();
            d_done = (cc_ramstate == ACCESS);
            i_done = ~iwait;
            tick();
            if (d_act && d_done) begin
                d_act = 1'b0;
                d_gap = $urandom_range(0, 2);
            end
            if (!d_act) begin
                if (d_gap == 0 && issue) begin
                    op = $urandom_range(0, 3);
                    a  = 32'h200 + 32'($urandom_range(0, 63)) * 4;
                    d  = $urandom;
                    cc_ramaddr  = a;
                    cc_ramstore = d;
                    cc_ramREN   = (op != 2);
                    cc_ramWEN   = (op >= 2);
                    if (op >= 2) begin
                        ref_mem[a[9:2]] = d;
                        dq.push_back('{wr: 1'b1, addr: a, data: d});
                    end else begin
                        dq.push_back('{wr: 1'b0, addr: a, data: ref_mem[a[9:2]]});
                    end
                    d_act = 1'b1;
                end else begin
                    cc_ramREN = 1'b0; cc_ramWEN = 1'b0;
                    if (d_gap > 0) d_gap--;
                end
            end
            for (int c = 0; c < 2; c++) begin
                if (i_act[c] && i_done[c]) begin
                    i_act[c] = 1'b0;
                    i_gap[c] = $urandom_range(0, 3);
                end
                if (!i_act[c]) begin
                    if (i_gap[c] == 0 && issue) begin
                        a = 32'h80 + 32'($urandom_range(0, 95)) * 4;
                        iaddr[c] = a;
                        iREN[c]  = 1'b1;
                        if (c == 0) iq0.push_back(hashw(a));
                        else        iq1.push_back(hashw(a));
                        i_act[c] = 1'b1;
                    end else begin
                        iREN[c] = 1'b0;
                        if (i_gap[c] > 0) i_gap[c]--;
                    end
                end
            end
        end
        cc_ramREN = 1'b0; cc_ramWEN = 1'b0; iREN = 2'b00;
        repeat (3) samp();
        mon_en = 1'b0;
        chk("drain_data_queue", 32'(dq.size()), 32'd0);
        chk("drain_icache0_queue", 32'(iq0.size()), 32'd0);
        chk("drain_icache1_queue", 32'(iq1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
